nios_cpu_pio_in_edge: RTL and testbench

Parametrised Avalon-MM input PIO for the Nios control subsystem, successor to the fixed 4-bit command input port. Provides a synchronised level-read register plus per-bit edge capture with write-1-to-clear and a maskable interrupt to the CPU. It sits between asynchronous board/PLL status lines and the Nios data bus.

---
 rtl/nios_cpu_pio_in_edge.sv | 123 ++++++++++++
 tb/tb_nios_cpu_pio_in_edge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/nios_cpu_pio_in_edge.sv
// Avalon-MM input PIO: synchronised level-read DATA register; with PIO_IN_EDGE_IRQ_EN defined,
// adds per-bit edge capture (write-1-to-clear), an IRQ mask and a registered level interrupt.
module nios_cpu_pio_in_edge #(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_CAPT = 2'd3
  } reg_addr_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data;
  logic [31:0]      rd_next;

  // NOTE: non-blocking assignments make every stage take its predecessor's old value,
  // so the chain shifts exactly one stage per clock whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign data = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_EDGE_IRQ_EN
  localparam logic [2:0] SETTLE_DONE = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] capture_q;
  logic [WIDTH-1:0] capture_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clear_bits;
  logic [2:0]       settle_q;
  logic             armed;
  logic             wr_mask;
  logic             wr_capt;

  // Edges stay blind until the synchroniser and prev hold real input values.
  assign armed   = (settle_q == SETTLE_DONE);
  assign wr_mask = chipselect & write & (address == ADDR_MASK);
  assign wr_capt = chipselect & write & (address == ADDR_CAPT);

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    edge_det = '0;
    if (armed) begin
      case (EDGE_TYPE)
        0:       edge_det = data & ~prev_q;
        1:       edge_det = ~data & prev_q;
        default: edge_det = data ^ prev_q;
      endcase
    end
    clear_bits = wr_capt ? writedata[WIDTH-1:0] : '0;
    // A new edge overrides a same-cycle clear of that bit.
    capture_d  = (capture_q & ~clear_bits) | edge_det;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= '0;
      mask_q    <= '0;
      capture_q <= '0;
      settle_q  <= '0;
      irq       <= 1'b0;
    end else begin
      prev_q    <= data;
      capture_q <= capture_d;
      if (!armed) settle_q <= settle_q + 3'd1;
      if (wr_mask) mask_q <= writedata[WIDTH-1:0];
      // Uses the new capture but the old mask: a mask write reaches irq one edge later.
      irq       <= |(capture_d & mask_q);
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next = 32'(data);
      ADDR_MASK: rd_next = 32'(mask_q);
      ADDR_CAPT: rd_next = 32'(capture_q);
      default:   rd_next = '0;
    endcase
  end
`else
  logic unused_ctrl;

  assign unused_ctrl = ^{chipselect, write, 2'(EDGE_TYPE)};
  assign irq         = 1'b0;

  always_comb begin
    rd_next = '0;
    if (address == ADDR_DATA) rd_next = 32'(data);
  end
`endif

  logic unused_wdata;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_next;
  end

endmodule

// File: tb/tb_nios_cpu_pio_in_edge.sv
// Directed bench for nios_cpu_pio_in_edge (WIDTH=4, SYNC_STAGES=2); a rising-edge and an
// any-edge instance share the bus. Expectations follow the build's PIO_IN_EDGE_IRQ_EN setting.
module tb_nios_cpu_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset;
  logic        reset2;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] readdata2;
  logic [3:0]  in_port;
  logic [3:0]  in_port2;
  logic        irq;
  logic        irq2;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  nios_cpu_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  nios_cpu_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_dut_any (
    .clk        (clk),
    .reset      (reset2),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata2),
    .in_port    (in_port2),
    .irq        (irq2)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write      = 1'b1;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
  endtask

  initial begin
    reset      = 1'b1;
    reset2     = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    in_port    = 4'hF;
    in_port2   = 4'h0;

    @(negedge clk);
    tick(2);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);

    // Inputs held high through reset: DATA settles, no spurious capture.
    reset = 1'b0;
    tick(4);
    check("data_after_settle", readdata, 32'h0000_000F);
    check("irq_no_spurious", 32'(irq), 32'h0);
    address = 2'd3;
    tick();
    check("capt_no_spurious", readdata, 32'h0);
    address = 2'd1;
    tick();
    check("reserved_reads_0", readdata, 32'h0);

    // DATA latency: change before E0, readdata shows it after E0+2.
    address = 2'd0;
    in_port = 4'h0;
    tick(2);
    check("data_latency_old", readdata, 32'h0000_000F);
    tick();
    check("data_latency_new", readdata, 32'h0);
    bus_write(2'd0, 32'hFFFF_FFFF);
    tick();
    check("data_write_ignored", readdata, 32'h0);

`ifdef PIO_IN_EDGE_IRQ_EN
    bus_write(2'd2, 32'h1);
    address = 2'd2;
    tick();
    check("mask_readback", readdata, 32'h1);

    // Rising edge on bit 0: irq rises at E0+2.
    address = 2'd3;
    in_port = 4'h1;
    tick(2);
    check("irq_before_edge", 32'(irq), 32'h0);
    tick();
    check("irq_rise", 32'(irq), 32'h1);
    tick();
    check("capt_rise", readdata, 32'h1);

    bus_write(2'd3, 32'h1);
    check("irq_after_w1c", 32'(irq), 32'h0);
    tick();
    check("capt_after_w1c", readdata, 32'h0);

    // Re-capture bit 0, then land a second rising edge on the same edge as its W1C.
    in_port = 4'h0;
    tick(3);
    in_port = 4'h1;
    tick(3);
    check("irq_rise_again", 32'(irq), 32'h1);
    in_port = 4'h0;
    tick(3);
    in_port = 4'h1;
    tick(2);
    address    = 2'd3;
    chipselect = 1'b1;
    write      = 1'b1;
    writedata  = 32'h1;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    check("irq_set_wins", 32'(irq), 32'h1);
    tick();
    check("capt_set_wins", readdata, 32'h1);

    bus_write(2'd3, 32'hF);
    check("irq_clear_all", 32'(irq), 32'h0);

    // Any-edge instance, mask 0: a high-then-low pulse on bit 2 captures but stays quiet.
    reset2 = 1'b0;
    tick(4);
    in_port2 = 4'h4;
    tick(3);
    in_port2 = 4'h0;
    tick(3);
    check("any_irq_masked", 32'(irq2), 32'h0);
    address = 2'd3;
    tick();
    check("any_capture", readdata2, 32'h0000_0004);
    bus_write(2'd2, 32'h4);
    check("any_irq_mask_edge", 32'(irq2), 32'h0);
    tick();
    check("any_irq_after_mask", 32'(irq2), 32'h1);
    check("rise_irq_other_capt", 32'(irq), 32'h0);

    // Fill capture and mask, then a single-cycle reset clears everything.
    bus_write(2'd2, 32'hF);
    in_port = 4'h0;
    tick(3);
    in_port = 4'hF;
    tick(3);
    check("irq_all", 32'(irq), 32'h1);
    address = 2'd3;
    tick();
    check("capt_all", readdata, 32'h0000_000F);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid_readdata", readdata, 32'h0);
    check("reset_mid_irq", 32'(irq), 32'h0);
    tick();
    check("reset_mid_capture", readdata, 32'h0);
    address = 2'd2;
    tick();
    check("reset_mid_mask", readdata, 32'h0);
    check("reset_mid_irq_hold", 32'(irq), 32'h0);
`else
    bus_write(2'd2, 32'hF);
    address = 2'd2;
    tick();
    check("mask_disabled", readdata, 32'h0);
    in_port = 4'h5;
    tick(3);
    address = 2'd3;
    tick();
    check("capt_disabled", readdata, 32'h0);
    check("irq_disabled", 32'(irq), 32'h0);
    address = 2'd0;
    tick();
    check("data_0x5", readdata, 32'h0000_0005);

    reset2   = 1'b0;
    in_port2 = 4'hA;
    tick(4);
    check("any_data", readdata2, 32'h0000_000A);
    check("any_irq_disabled", 32'(irq2), 32'h0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid_readdata", readdata, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
